// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared geometry, colour type and framebuffer state encodings for the HUB75
// panel path. The scan driver imports the same package, so the panel size and
// the FB_* state values only ever live here.
// Ports: none (package).
// ---------------------------------------------------------------------------
package hub75_pkg;

  localparam int WIDTH          = 32;
  localparam int HEIGHT         = 32;
  localparam int ROWS_PER_GROUP = HEIGHT / 2;
  localparam int CW             = 3;

  localparam int X_W  = $clog2(WIDTH);
  localparam int Y_W  = $clog2(HEIGHT);
  localparam int RG_W = $clog2(ROWS_PER_GROUP);
  // One framebuffer address is {bank, row_group, col}
  localparam int AW   = 1 + RG_W + X_W;

  typedef logic [CW-1:0] rgb_t;

  typedef enum logic [1:0] {
    FB_IDLE      = 2'd0,
    FB_CLEAR     = 2'd1,
    FB_SWAP_WAIT = 2'd2
  } fb_state_t;

  // Packs bank / row group / column into a RAM address
  function automatic logic [AW-1:0] fbAddr(input logic bank,
                                            input logic [RG_W-1:0] row,
                                            input logic [X_W-1:0] col);
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/hub75_framebuffer_if.sv
// ---------------------------------------------------------------------------
// hub75_framebuffer_if
// Bundles the producer write port, the buffer control (clear / swap) and the
// scan-driver read port of the framebuffer.
//   master : producer + scan driver side (drives requests, reads status/data)
//   slave  : framebuffer side
// Signals:
//   wr_valid/wr_ready/wr_x/wr_y/wr_rgb  pixel write handshake
//   clear_req/swap_req                   single-cycle control pulses
//   swap_done/busy/front_sel             status
//   frame_end                            end-of-frame pulse from scan driver
//   rd_en/rd_col/rd_row                  column read request
//   rd_top_rgb/rd_bot_rgb/rd_valid       pixel pair, one cycle later
// ---------------------------------------------------------------------------
interface hub75_framebuffer_if;
  import hub75_pkg::*;

  logic            wr_valid;
  logic            wr_ready;
  logic [X_W-1:0]  wr_x;
  logic [Y_W-1:0]  wr_y;
  rgb_t            wr_rgb;

  logic            clear_req;
  logic            swap_req;
  logic            swap_done;
  logic            busy;
  logic            front_sel;
  logic            frame_end;

  logic            rd_en;
  logic [X_W-1:0]  rd_col;
  logic [RG_W-1:0] rd_row;
  rgb_t            rd_top_rgb;
  rgb_t            rd_bot_rgb;
  logic            rd_valid;

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb,
    output clear_req, swap_req, frame_end,
    output rd_en, rd_col, rd_row,
    input  wr_ready, swap_done, busy, front_sel,
    input  rd_top_rgb, rd_bot_rgb, rd_valid
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb,
    input  clear_req, swap_req, frame_end,
    input  rd_en, rd_col, rd_row,
    output wr_ready, swap_done, busy, front_sel,
    output rd_top_rgb, rd_bot_rgb, rd_valid
  );

endinterface

// File: rtl/hub75_fb_ram.sv
// ---------------------------------------------------------------------------
// hub75_fb_ram
// Simple dual-port RAM: one write port, one read port with a registered read.
// Storage is not reset; only the read data register is, so the scan outputs
// come up as zero.
// Ports:
//   clk, reset_n       clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i       read request; rdata_o updates on the next edge and
//                      holds while re_i is low
//   rdata_o            registered read data
// ---------------------------------------------------------------------------
module hub75_fb_ram #(
  parameter  int DEPTH = 1024,
  parameter  int DW    = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port: plain synchronous write, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read port: data registered only on a request, so it holds otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hub75_framebuffer.sv
// ---------------------------------------------------------------------------
// hub75_framebuffer
// Double-buffered 32x32 RGB framebuffer for the HUB75 scan driver. The
// producer writes the back bank; the scan driver reads the front bank as
// top/bottom pixel pairs. A requested swap waits for frame_end so a frame is
// never torn, and clear_req zeroes the back bank in hardware.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   fb            hub75_framebuffer_if.slave (write, control and read ports)
// ---------------------------------------------------------------------------
module hub75_framebuffer
  import hub75_pkg::*;
(
  input logic                clk,
  input logic                reset_n,
  hub75_framebuffer_if.slave fb
);

  localparam logic [RG_W+X_W-1:0] CLR_LAST = (RG_W+X_W)'(ROWS_PER_GROUP*WIDTH - 1);

  fb_state_t             state_q;
  logic                  frontSel_q;
  logic                  swapPending_q;
  logic                  swapDone_q;
  logic                  rdValid_q;
  logic [RG_W+X_W-1:0]   clrAddr_q;

  logic                  clearing;
  logic                  wrAccept;
  logic                  wrXOk;
  logic                  wrYOk;
  logic                  wrTop;
  logic [RG_W-1:0]       wrRow;
  logic [AW-1:0]         ramWaddr;
  rgb_t                  ramWdata;
  logic                  topWe;
  logic                  botWe;
  logic [AW-1:0]         rdAddr;

  assign clearing    = (state_q == FB_CLEAR);
  assign fb.wr_ready = (state_q == FB_IDLE);
  assign fb.busy     = (state_q != FB_IDLE);
  assign wrAccept    = fb.wr_valid && fb.wr_ready;

  // Range checks only exist when the panel does not fill the coordinate width
  if (WIDTH < (1 << X_W)) begin : g_xChk
    assign wrXOk = ({1'b0, fb.wr_x} < (X_W+1)'(WIDTH));
  end else begin : g_xAll
    assign wrXOk = 1'b1;
  end

  if (HEIGHT < (1 << Y_W)) begin : g_yChk
    assign wrYOk = ({1'b0, fb.wr_y} < (Y_W+1)'(HEIGHT));
  end else begin : g_yAll
    assign wrYOk = 1'b1;
  end

  // Upper half of the panel lives in the top RAM, lower half in the bottom RAM
  assign wrTop = (fb.wr_y < Y_W'(ROWS_PER_GROUP));
  assign wrRow = wrTop ? fb.wr_y[RG_W-1:0]
                       : RG_W'(fb.wr_y - Y_W'(ROWS_PER_GROUP));

  // Clear takes over both write ports; it always targets the back bank
  assign ramWaddr = clearing ? {~frontSel_q, clrAddr_q}
                             : fbAddr(~frontSel_q, wrRow, fb.wr_x);
  assign ramWdata = clearing ? '0 : fb.wr_rgb;
  assign topWe    = clearing || (wrAccept && wrXOk && wrYOk && wrTop);
  assign botWe    = clearing || (wrAccept && wrXOk && wrYOk && !wrTop);

  // Reads use the pre-edge front_sel, so a read on the swap edge sees the old frame
  assign rdAddr = fbAddr(frontSel_q, fb.rd_row, fb.rd_col);

  // Buffer control FSM: clear sweep, deferred swap on frame_end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FB_IDLE;
      frontSel_q    <= 1'b0;
      swapPending_q <= 1'b0;
      clrAddr_q     <= '0;
      swapDone_q    <= 1'b0;
    end else begin
      swapDone_q <= 1'b0;
      case (state_q)
        FB_IDLE: begin
          if (fb.clear_req) begin
            state_q       <= FB_CLEAR;
            clrAddr_q     <= '0;
            swapPending_q <= fb.swap_req;
          end else if (fb.swap_req) begin
            state_q <= FB_SWAP_WAIT;
          end
        end
        FB_CLEAR: begin
          clrAddr_q <= clrAddr_q + 1'b1;
          if (clrAddr_q == CLR_LAST) begin
            swapPending_q <= 1'b0;
            state_q <= (swapPending_q || fb.swap_req) ? FB_SWAP_WAIT : FB_IDLE;
          end else if (fb.swap_req) begin
            swapPending_q <= 1'b1;
          end
        end
        FB_SWAP_WAIT: begin
          if (fb.frame_end) begin
            frontSel_q <= ~frontSel_q;
            swapDone_q <= 1'b1;
            state_q    <= FB_IDLE;
          end
        end
        default: state_q <= FB_IDLE;
      endcase
    end
  end

  // Read-valid tracks rd_en with the same one-cycle latency as the RAM data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= fb.rd_en;
    end
  end

  assign fb.swap_done = swapDone_q;
  assign fb.front_sel = frontSel_q;
  assign fb.rd_valid  = rdValid_q;

  hub75_fb_ram #(.DEPTH(1 << AW), .DW(CW)) u_topRam (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (topWe),
    .waddr_i (ramWaddr),
    .wdata_i (ramWdata),
    .re_i    (fb.rd_en),
    .raddr_i (rdAddr),
    .rdata_o (fb.rd_top_rgb)
  );

  hub75_fb_ram #(.DEPTH(1 << AW), .DW(CW)) u_botRam (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (botWe),
    .waddr_i (ramWaddr),
    .wdata_i (ramWdata),
    .re_i    (fb.rd_en),
    .raddr_i (rdAddr),
    .rdata_o (fb.rd_bot_rgb)
  );

endmodule

// File: tb/tb_hub75_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_hub75_framebuffer
// Directed, self-checking bench for hub75_framebuffer: clear, write/swap/read
// of a small pixel table, swap timing corners, writes while busy and an
// asynchronous reset in the middle of a clear.
// ---------------------------------------------------------------------------
module tb_hub75_framebuffer;
  import hub75_pkg::*;

  typedef struct {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] rgb;
    logic [3:0] row;
    logic [2:0] expTop;
    logic [2:0] expBot;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   fails  = 0;
  int   lowCnt;
  int   doneCnt;
  vec_t vecs[8];

  hub75_framebuffer_if fb();

  hub75_framebuffer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fb      (fb)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One write attempt; expReady states whether the port should accept it
  task automatic applyStimulus(input logic [4:0] x, input logic [4:0] y,
                               input logic [2:0] rgb, input logic expReady);
    fb.wr_valid = 1'b1;
    fb.wr_x     = x;
    fb.wr_y     = y;
    fb.wr_rgb   = rgb;
    checkOutput("wr_ready", 32'(fb.wr_ready), 32'(expReady));
    tick();
    fb.wr_valid = 1'b0;
  endtask

  // Single read of the front bank with one-cycle latency
  task automatic readCheck(input string name, input logic [4:0] col,
                           input logic [3:0] row, input logic [2:0] expTop,
                           input logic [2:0] expBot);
    fb.rd_en  = 1'b1;
    fb.rd_col = col;
    fb.rd_row = row;
    tick();
    fb.rd_en = 1'b0;
    checkOutput({name, "_valid"}, 32'(fb.rd_valid), 32'd1);
    checkOutput({name, "_top"}, 32'(fb.rd_top_rgb), 32'(expTop));
    checkOutput({name, "_bot"}, 32'(fb.rd_bot_rgb), 32'(expBot));
  endtask

  task automatic pulseClear();
    fb.clear_req = 1'b1;
    tick();
    fb.clear_req = 1'b0;
  endtask

  task automatic pulseSwap();
    fb.swap_req = 1'b1;
    tick();
    fb.swap_req = 1'b0;
  endtask

  task automatic pulseFrameEnd(input string name, input logic expSwap,
                               input logic expFront);
    fb.frame_end = 1'b1;
    tick();
    fb.frame_end = 1'b0;
    checkOutput({name, "_swap_done"}, 32'(fb.swap_done), 32'(expSwap));
    checkOutput({name, "_front_sel"}, 32'(fb.front_sel), 32'(expFront));
    if (expSwap) begin
      tick();
      checkOutput({name, "_swap_done_clr"}, 32'(fb.swap_done), 32'd0);
      checkOutput({name, "_busy"}, 32'(fb.busy), 32'd0);
    end
  endtask

  // Counts cycles until busy drops, bounded
  task automatic waitIdle(input string name, input int expCycles);
    int count;
    count = 0;
    while (fb.busy && count < 2000) begin
      tick();
      count++;
    end
    checkOutput(name, 32'(count), 32'(expCycles));
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_busy"}, 32'(fb.busy), 32'd0);
    checkOutput({name, "_wr_ready"}, 32'(fb.wr_ready), 32'd1);
    checkOutput({name, "_front_sel"}, 32'(fb.front_sel), 32'd0);
    checkOutput({name, "_swap_done"}, 32'(fb.swap_done), 32'd0);
    checkOutput({name, "_rd_valid"}, 32'(fb.rd_valid), 32'd0);
    checkOutput({name, "_rd_top"}, 32'(fb.rd_top_rgb), 32'd0);
    checkOutput({name, "_rd_bot"}, 32'(fb.rd_bot_rgb), 32'd0);
  endtask

  initial begin
    // Pixel table: all written first, then read back, so later writes win
    vecs[0] = '{5'd5,  5'd3,  3'b001, 4'd3,  3'b001, 3'b100};
    vecs[1] = '{5'd5,  5'd19, 3'b100, 4'd3,  3'b001, 3'b100};
    vecs[2] = '{5'd0,  5'd0,  3'b111, 4'd0,  3'b111, 3'b000};
    vecs[3] = '{5'd31, 5'd31, 3'b010, 4'd15, 3'b110, 3'b010};
    vecs[4] = '{5'd31, 5'd15, 3'b110, 4'd15, 3'b110, 3'b010};
    vecs[5] = '{5'd16, 5'd16, 3'b101, 4'd0,  3'b000, 3'b101};
    vecs[6] = '{5'd12, 5'd7,  3'b011, 4'd7,  3'b110, 3'b000};
    vecs[7] = '{5'd12, 5'd7,  3'b110, 4'd7,  3'b110, 3'b000};

    fb.wr_valid  = 1'b0;
    fb.wr_x      = '0;
    fb.wr_y      = '0;
    fb.wr_rgb    = '0;
    fb.clear_req = 1'b0;
    fb.swap_req  = 1'b0;
    fb.frame_end = 1'b0;
    fb.rd_en     = 1'b0;
    fb.rd_col    = '0;
    fb.rd_row    = '0;
    reset_n      = 1'b1;

    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset_n = 1'b1;
    tick();

    // Initialise both banks: clear bank 1, swap, clear bank 0, swap back
    pulseClear();
    waitIdle("clear0_cycles", 512);
    pulseSwap();
    pulseFrameEnd("init_swap1", 1'b1, 1'b1);
    pulseClear();
    waitIdle("clear1_cycles", 512);
    pulseSwap();
    pulseFrameEnd("init_swap0", 1'b1, 1'b0);

    // Back-to-back sweep of every front address
    for (int r = 0; r < ROWS_PER_GROUP; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        fb.rd_en  = 1'b1;
        fb.rd_col = 5'(c);
        fb.rd_row = 4'(r);
        tick();
        checkOutput("sweep_valid", 32'(fb.rd_valid), 32'd1);
        checkOutput("sweep_top", 32'(fb.rd_top_rgb), 32'd0);
        checkOutput("sweep_bot", 32'(fb.rd_bot_rgb), 32'd0);
      end
    end
    fb.rd_en = 1'b0;
    tick();
    checkOutput("sweep_end_valid", 32'(fb.rd_valid), 32'd0);

    // Table writes land in the back bank; front stays zero until the swap
    foreach (vecs[i]) applyStimulus(vecs[i].x, vecs[i].y, vecs[i].rgb, 1'b1);
    foreach (vecs[i]) readCheck("preswap", vecs[i].x, vecs[i].row, 3'b000, 3'b000);
    pulseSwap();
    repeat (9) tick();
    checkOutput("wait_swap_done", 32'(fb.swap_done), 32'd0);
    checkOutput("wait_front_sel", 32'(fb.front_sel), 32'd0);
    checkOutput("wait_busy", 32'(fb.busy), 32'd1);
    pulseFrameEnd("tbl_swap", 1'b1, 1'b1);
    foreach (vecs[i]) readCheck("tbl", vecs[i].x, vecs[i].row, vecs[i].expTop, vecs[i].expBot);
    tick();
    checkOutput("hold_valid", 32'(fb.rd_valid), 32'd0);
    checkOutput("hold_top", 32'(fb.rd_top_rgb), 32'(3'b110));

    // frame_end in the same cycle as swap_req does not complete the swap
    fb.swap_req  = 1'b1;
    fb.frame_end = 1'b1;
    tick();
    fb.swap_req  = 1'b0;
    fb.frame_end = 1'b0;
    checkOutput("same_cyc_swap_done", 32'(fb.swap_done), 32'd0);
    checkOutput("same_cyc_front_sel", 32'(fb.front_sel), 32'd1);
    checkOutput("same_cyc_busy", 32'(fb.busy), 32'd1);
    repeat (3) tick();
    pulseFrameEnd("same_cyc_next", 1'b1, 1'b0);

    // clear_req with swap_req: 512 clear cycles, then wait for frame_end
    fb.clear_req = 1'b1;
    fb.swap_req  = 1'b1;
    tick();
    fb.clear_req = 1'b0;
    fb.swap_req  = 1'b0;
    lowCnt  = 0;
    doneCnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (!fb.wr_ready) lowCnt++;
      if (fb.swap_done) doneCnt++;
      fb.frame_end = (i == 100);
      tick();
    end
    fb.frame_end = 1'b0;
    checkOutput("clrswap_ready_low", 32'(lowCnt), 32'd512);
    checkOutput("clrswap_no_early_swap", 32'(doneCnt), 32'd0);
    checkOutput("clrswap_busy", 32'(fb.busy), 32'd1);
    checkOutput("clrswap_front_sel", 32'(fb.front_sel), 32'd0);
    pulseFrameEnd("clrswap", 1'b1, 1'b1);
    foreach (vecs[i]) readCheck("clrswap_rd", vecs[i].x, vecs[i].row, 3'b000, 3'b000);

    // Writes while busy are refused; swap_req during CLEAR is remembered
    pulseClear();
    applyStimulus(5'd9, 5'd20, 3'b110, 1'b0);
    pulseSwap();
    repeat (510) tick();
    checkOutput("pending_swap_busy", 32'(fb.busy), 32'd1);
    applyStimulus(5'd9, 5'd4, 3'b101, 1'b0);
    pulseFrameEnd("pending_swap", 1'b1, 1'b0);
    readCheck("dropped_wr", 5'd9, 4'd4, 3'b000, 3'b000);
    applyStimulus(5'd10, 5'd6, 3'b011, 1'b1);
    applyStimulus(5'd10, 5'd22, 3'b101, 1'b1);
    readCheck("front_unchanged", 5'd10, 4'd6, 3'b000, 3'b000);
    pulseSwap();
    pulseFrameEnd("back_swap", 1'b1, 1'b1);
    readCheck("back_data", 5'd10, 4'd6, 3'b011, 3'b101);

    // Asynchronous reset in the middle of a clear
    pulseClear();
    repeat (100) tick();
    fb.rd_en  = 1'b1;
    fb.rd_col = 5'd10;
    fb.rd_row = 4'd6;
    tick();
    checkOutput("pre_rst_busy", 32'(fb.busy), 32'd1);
    checkOutput("pre_rst_valid", 32'(fb.rd_valid), 32'd1);
    checkOutput("pre_rst_top", 32'(fb.rd_top_rgb), 32'(3'b011));
    #2 reset_n = 1'b0;
    #1;
    checkResetValues("mid_rst");
    fb.rd_en = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    checkOutput("post_rst_busy", 32'(fb.busy), 32'd0);
    pulseClear();
    waitIdle("post_rst_clear", 512);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hub75_framebuffer.md
Name: hub75_framebuffer

Overview:
- Double-buffered 32x32 RGB framebuffer feeding the HUB75 scan/shift driver, which today generates its pixels internally.
- Producer logic (sprite renderer, text engine) writes pixels into the back buffer. The scan driver reads the front buffer as top/bottom pixel pairs, one column per request.
- Buffer swap is requested by the producer and executed only on the scan driver's frame_end pulse, so a frame is never torn.
- Also provides a hardware clear of the back buffer.

Parameters:
- WIDTH, 32, panel columns; sets rd_col/wr_x range.
- HEIGHT, 32, panel rows; top half is rows 0..HEIGHT/2-1, bottom half is rows HEIGHT/2..HEIGHT-1.
- CW, 3, colour bits per pixel, {r,g,b}.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- wr_valid, input, 1, pixel write request.
- wr_ready, output, 1, write accepted when wr_valid && wr_ready.
- wr_x, input, 5, write column.
- wr_y, input, 5, write row (0..HEIGHT-1).
- wr_rgb, input, CW, write colour.
- clear_req, input, 1, single-cycle pulse: zero the back buffer.
- swap_req, input, 1, single-cycle pulse: make the back buffer the front buffer at the next frame_end.
- swap_done, output, 1, single-cycle pulse when the swap takes effect.
- busy, output, 1, high in CLEAR or SWAP_WAIT.
- front_sel, output, 1, index of the bank currently displayed.
- frame_end, input, 1, pulse from the scan driver after the last row group is shown.
- rd_en, input, 1, read request from the scan driver.
- rd_col, input, 5, read column.
- rd_row, input, 4, row group (0..HEIGHT/2-1).
- rd_top_rgb, output, CW, pixel at (rd_col, rd_row).
- rd_bot_rgb, output, CW, pixel at (rd_col, rd_row+HEIGHT/2).
- rd_valid, output, 1, read data valid.

Behaviour:
Storage
- Two memories, top and bottom. Each has 2*(HEIGHT/2)*WIDTH entries of CW bits.
- Address is {bank, row_group, col}.
- Memory contents are NOT reset. Software or a test bench must issue clear_req before first use.

Reset values
- state=IDLE, front_sel=0, swap_pending=0, clr_addr=0.
- rd_valid=0, rd_top_rgb=0, rd_bot_rgb=0, swap_done=0.
- busy=0, wr_ready=1 (wr_ready is derived as state==IDLE).

Read path (independent of state)
- rd_en sampled at edge N; front bank (front_sel value before edge N) is read.
- rd_top_rgb/rd_bot_rgb/rd_valid are registered at edge N+1, giving 1-cycle latency.
- When rd_en=0: rd_valid=0 next cycle and rgb outputs hold their last value.
- Back-to-back reads are allowed every cycle.

Write path
- Write accepted only in IDLE.
- wr_y < HEIGHT/2 goes to the top memory at row wr_y. wr_y >= HEIGHT/2 goes to the bottom memory at row wr_y-HEIGHT/2.
- Always written to bank ~front_sel.
- Writes with wr_x >= WIDTH or wr_y >= HEIGHT are accepted and dropped.

State machine
- IDLE:
  - clear_req -> CLEAR, clr_addr=0. If swap_req is in the same cycle, set swap_pending.
  - else swap_req -> SWAP_WAIT.
  - frame_end in IDLE has no effect.
- CLEAR:
  - Writes 0 to both memories at {~front_sel, clr_addr} each cycle.
  - After (HEIGHT/2)*WIDTH cycles (512 at defaults): if swap_pending, go to SWAP_WAIT and clear swap_pending; else go to IDLE.
  - swap_req during CLEAR sets swap_pending. clear_req during CLEAR is ignored.
- SWAP_WAIT:
  - On the first frame_end sampled while in SWAP_WAIT: front_sel toggles, swap_done=1 for one cycle, go to IDLE.
  - A frame_end in the same cycle as the swap_req that caused entry does not count.
  - clear_req and swap_req are ignored in this state.
- busy = (state != IDLE).

Reset mid-operation
- Asynchronous reset returns all state to reset values immediately.
- A partially cleared buffer stays partially cleared.

Decomposition:
- Package hub75_pkg holds:
  - WIDTH, HEIGHT, ROWS_PER_GROUP=HEIGHT/2, CW.
  - rgb_t (CW-bit colour).
  - Framebuffer state encodings FB_IDLE=0, FB_CLEAR=1, FB_SWAP_WAIT=2.
  - These are shared with the scan driver.
- Sub-module hub75_fb_ram: simple dual-port RAM, one write port and one read port with registered read, parameterised depth/width. It is instantiated twice (top, bottom). The clear datapath muxes into its write port.

Test Plan:
- Reset, clear_req, wait for busy=0 (512 cycles), rd_en for all 16x32 addresses -> every rd_top_rgb/rd_bot_rgb=0, rd_valid one cycle after each rd_en.
- Write (x=5,y=3,rgb=3'b001) and (x=5,y=19,rgb=3'b100), swap_req, pulse frame_end 10 cycles later -> swap_done pulse on that edge, front_sel=1. Read col=5,row=3 -> top=3'b001, bot=3'b100. Reads before the swap return 0.
- swap_req and frame_end in the same cycle -> no swap. The next frame_end -> swap_done, front_sel toggles.
- clear_req and swap_req in the same cycle -> wr_ready=0 for 512 cycles, then SWAP_WAIT. frame_end -> swap. New front reads all 0.
- wr_valid during CLEAR/SWAP_WAIT -> wr_ready=0, no write. Data written after returning to IDLE only lands in the back bank; front reads are unchanged.
- Assert reset_n low midway through CLEAR -> outputs return to reset values asynchronously, state IDLE, front_sel=0, wr_ready=1.
